// File: rtl/dma_read_drain_scheduler.sv
// Drains the A/B DMA-read completion paths into the device-memory write port.
// Requests complete in issue order; each request's bytes leave as address-tagged bursts
// taken from the selected path's burst-descriptor and data show-ahead FIFOs.
module dma_read_drain_scheduler #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CTR_W       = 8,
  parameter int unsigned ORDER_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              issue_valid,
  input  logic              issue_path,
  input  logic [31:0]       issue_size,
  output logic              order_full,
  input  logic              a_burst_empty,
  input  logic [ADDR_W-1:0] a_burst_addr,
  input  logic [CTR_W-1:0]  a_burst_ctr,
  output logic              a_burst_rd_en,
  input  logic              b_burst_empty,
  input  logic [ADDR_W-1:0] b_burst_addr,
  input  logic [CTR_W-1:0]  b_burst_ctr,
  output logic              b_burst_rd_en,
  input  logic              a_data_empty,
  input  logic [DATA_W-1:0] a_data_dout,
  input  logic [3:0]        a_data_dwen,
  output logic              a_data_rd_en,
  input  logic              b_data_empty,
  input  logic [DATA_W-1:0] b_data_dout,
  input  logic [3:0]        b_data_dwen,
  output logic              b_data_rd_en,
  output logic              dev_valid,
  input  logic              dev_ready,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_data,
  output logic [3:0]        dev_dwen,
  output logic              dev_first,
  output logic              dev_last,
  output logic              req_done,
  output logic              req_done_path,
  output logic              err
);

  localparam int unsigned OrdAw = $clog2(ORDER_DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDesc = 2'd2;
  localparam logic [1:0] StData = 2'd3;

  // Issue-order FIFO: {path, size}; extra pointer bit distinguishes full from empty.
  logic [32:0]    ord_mem [ORDER_DEPTH];
  logic [OrdAw:0] ord_wr_q, ord_rd_q;
  logic           ord_empty, ord_full, ord_pop, ord_push, ord_drop;
  logic [32:0]    ord_head;

  logic [1:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic [31:0]       rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CTR_W:0]    beats_q, beats_d;
  logic              first_q, first_d;
  logic              done_q, done_d;
  logic              done_path_q, done_path_d;
  logic              err_q, err_d;

  logic              sel_burst_empty, sel_data_empty;
  logic [ADDR_W-1:0] sel_burst_addr;
  logic [CTR_W-1:0]  sel_burst_ctr;
  logic [DATA_W-1:0] sel_data_dout;
  logic [3:0]        sel_data_dwen;
  logic              in_data, accept, burst_pop, is_last, over;
  logic [31:0]       beat_bytes, rem_next;

  // Bytes carried by a beat, set by its highest enabled DW.
  function automatic logic [31:0] dwen_bytes(input logic [3:0] d);
    casez (d)
      4'b1???: dwen_bytes = 32'd16;
      4'b01??: dwen_bytes = 32'd12;
      4'b001?: dwen_bytes = 32'd8;
      4'b0001: dwen_bytes = 32'd4;
      default: dwen_bytes = 32'd0;
    endcase
  endfunction

  // Order FIFO status and handshakes; a pop in the same cycle frees room for a write.
  always_comb begin
    ord_empty = (ord_wr_q == ord_rd_q);
    ord_full  = (ord_wr_q[OrdAw] != ord_rd_q[OrdAw]) &&
                (ord_wr_q[OrdAw-1:0] == ord_rd_q[OrdAw-1:0]);
    ord_head  = ord_mem[ord_rd_q[OrdAw-1:0]];
    ord_pop   = (state_q == StLoad);
    ord_push  = issue_valid && (!ord_full || ord_pop);
    ord_drop  = issue_valid && ord_full && !ord_pop;
  end

  // Order FIFO storage; data needs no reset.
  always_ff @(posedge i_clk) begin
    if (ord_push) ord_mem[ord_wr_q[OrdAw-1:0]] <= {issue_path, issue_size};
  end

  // Order FIFO pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ord_wr_q <= '0;
      ord_rd_q <= '0;
    end else begin
      if (ord_push) ord_wr_q <= ord_wr_q + 1'b1;
      if (ord_pop)  ord_rd_q <= ord_rd_q + 1'b1;
    end
  end

  // Selected-path muxing and beat handshake; reset blocks any pop immediately.
  always_comb begin
    sel_burst_empty = sel_q ? b_burst_empty : a_burst_empty;
    sel_burst_addr  = sel_q ? b_burst_addr  : a_burst_addr;
    sel_burst_ctr   = sel_q ? b_burst_ctr   : a_burst_ctr;
    sel_data_empty  = sel_q ? b_data_empty  : a_data_empty;
    sel_data_dout   = sel_q ? b_data_dout   : a_data_dout;
    sel_data_dwen   = sel_q ? b_data_dwen   : a_data_dwen;
    in_data         = (state_q == StData) && !i_rst;
    dev_valid       = in_data && !sel_data_empty;
    accept          = dev_valid && dev_ready;
    burst_pop       = (state_q == StDesc) && !sel_burst_empty && !i_rst;
    is_last         = (beats_q == (CTR_W+1)'(1));
    beat_bytes      = dwen_bytes(sel_data_dwen);
    over            = (beat_bytes > rem_q);
    rem_next        = over ? 32'd0 : rem_q - beat_bytes;
  end

  // Drain FSM next state and datapath updates.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    first_d     = first_q;
    done_d      = 1'b0;
    done_path_d = done_path_q;
    err_d       = err_q || ord_drop;
    case (state_q)
      StIdle: if (!ord_empty) state_d = StLoad;
      StLoad: begin
        sel_d = ord_head[32];
        rem_d = ord_head[31:0];
        if (ord_head[31:0] == 32'd0) begin
          done_d      = 1'b1;
          done_path_d = ord_head[32];
          state_d     = StIdle;
        end else begin
          state_d = StDesc;
        end
      end
      StDesc: if (burst_pop) begin
        addr_d  = sel_burst_addr;
        beats_d = {1'b0, sel_burst_ctr} + (CTR_W+1)'(1);
        first_d = 1'b1;
        state_d = StData;
      end
      StData: if (accept) begin
        addr_d  = addr_q + ADDR_W'(16);
        beats_d = beats_q - (CTR_W+1)'(1);
        rem_d   = rem_next;
        first_d = 1'b0;
        if (beat_bytes == 32'd0 || over) err_d = 1'b1;
        if (is_last) begin
          if (rem_next == 32'd0) begin
            done_d      = 1'b1;
            done_path_d = sel_q;
            state_d     = StIdle;
          end else begin
            state_d = StDesc;
          end
        end else if (rem_next == 32'd0) begin
          // Request exhausted mid-burst: flag it but keep draining the burst.
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      rem_q       <= '0;
      addr_q      <= '0;
      beats_q     <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      done_path_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      first_q     <= first_d;
      done_q      <= done_d;
      done_path_q <= done_path_d;
      err_q       <= err_d;
    end
  end

  // Output assignments; the non-selected path is never popped.
  always_comb begin
    order_full    = ord_full;
    a_burst_rd_en = burst_pop && !sel_q;
    b_burst_rd_en = burst_pop && sel_q;
    a_data_rd_en  = accept && !sel_q;
    b_data_rd_en  = accept && sel_q;
    dev_addr      = addr_q;
    dev_data      = in_data ? sel_data_dout : '0;
    dev_dwen      = in_data ? sel_data_dwen : 4'b0000;
    dev_first     = in_data && first_q;
    dev_last      = in_data && is_last;
    req_done      = done_q;
    req_done_path = done_path_q;
    err           = err_q;
  end

endmodule
